// File: rtl/imm_ext_pkg.sv
// Shared types and default widths for the immediate-extension pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imm_ext_pkg;

  localparam int IMM_IN_W  = 16;
  localparam int IMM_OUT_W = 32;
  localparam int IMM_TAG_W = 5;

  // Raw 2-bit mode field as it arrives on the input port.
  typedef logic [1:0] mode_t;

  typedef enum mode_t {
    MODE_SIGN   = 2'd0,
    MODE_ZERO   = 2'd1,
    MODE_UPPER  = 2'd2,
    MODE_BRANCH = 2'd3
  } mode_e;

  // Occupancy of the output register plus skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: SIGN / ZERO / UPPER / BRANCH.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result. BRANCH shift exists only with IMM_EXT_BRANCH_EN.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W   // must be at least IN_W+2
) (
  input  logic [IN_W-1:0]  imm,
  input  mode_t            mode,
  output logic [OUT_W-1:0] data,
  output logic             err
);

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;

  assign sign_ext  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zero_ext  = {{(OUT_W-IN_W){1'b0}}, imm};
  assign upper_ext = {imm, {(OUT_W-IN_W){1'b0}}};

  // Select the extension; unsupported BRANCH falls back to SIGN and flags err.
  always_comb begin
    data = sign_ext;
    err  = 1'b0;
    case (mode)
      MODE_SIGN:  data = sign_ext;
      MODE_ZERO:  data = zero_ext;
      MODE_UPPER: data = upper_ext;
      MODE_BRANCH: begin
`ifdef IMM_EXT_BRANCH_EN
        data = {sign_ext[OUT_W-3:0], 2'b00};
`else
        data = sign_ext;
        err  = 1'b1;
`endif
      end
      default: data = sign_ext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with one output register plus one skid entry; macro IMM_EXT_BRANCH_EN enables BRANCH mode.
// Latency: 1 cycle from acceptance to out_valid when the output is empty or draining.
// Backpressure: valid/ready; in_ready drops only when both entries are full and depends on state, never on out_ready.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W,
  parameter int TAG_W = IMM_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [15:0]      count
);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } res_t;

  state_e state, state_nxt;
  res_t   core_res, out_q, skid_q;
  logic   in_fire, out_fire;
  logic   load_out_in, load_out_skid, load_skid;

  // Extension is done once on the input side so both entries store finished results.
  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .data (core_res.data),
    .err  (core_res.err)
  );
  assign core_res.tag = in_tag;

  assign in_ready  = ~rst & (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_data = out_q.data;
  assign out_tag  = out_q.tag;
  assign out_err  = out_q.err;

  // Next occupancy and which entry loads from where.
  always_comb begin
    state_nxt     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          load_out_in = 1'b1;
          state_nxt   = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({in_fire, out_fire})
          2'b10: begin
            load_skid = 1'b1;
            state_nxt = ST_FULL;
          end
          2'b01: state_nxt = ST_EMPTY;
          2'b11: load_out_in = 1'b1;
          default: state_nxt = ST_ONE;
        endcase
      end
      ST_FULL: begin
        if (out_fire) begin
          load_out_skid = 1'b1;
          state_nxt     = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Occupancy register; reset discards both entries.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // Output and skid payloads; output holds steady unless a load is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_in)        out_q <= core_res;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= core_res;
    end
  end

  // Count of results taken downstream, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)           count <= '0;
    else if (out_fire) count <= count + 16'd1;
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe (default widths 16/32/5).
// Latency: n/a.
// Backpressure: randomized out_ready against a queue-based reference.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [15:0] exp_count;

  imm_extend_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: interpret the immediate as a signed integer and reduce modulo 2^32.
  function automatic exp_t ref_ext(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
    exp_t   r;
    longint s, v, m;
    m = 64'h1_0000_0000;
    s = longint'(imm);
    if (imm >= 16'h8000) s = s - 65536;
    r.err = 1'b0;
    case (mode)
      2'd0: v = s;
      2'd1: v = longint'(imm);
      2'd2: v = longint'(imm) * 65536;
      default: begin
`ifdef IMM_EXT_BRANCH_EN
        v = s * 4;
`else
        v = s;
        r.err = 1'b1;
`endif
      end
    endcase
    v = ((v % m) + m) % m;
    r.data = v[31:0];
    r.tag  = tag;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    q.delete();
    exp_count = '0;
    #1;
  endtask

  task automatic send_one(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag,
                          output logic vld, output logic [31:0] d, output logic [4:0] t, output logic e);
    in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vld = out_valid; d = out_data; t = out_tag; e = out_err;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_data !== 32'd0 || out_tag !== 5'd0 || out_err !== 1'b0)
      begin errors++; $display("FAIL reset_fields got %h/%0d/%b want 0/0/0", out_data, out_tag, out_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got %b want 1", in_ready); end
    q.delete();
    exp_count = '0;
  endtask

  task automatic test_modes();
    logic v, e; logic [31:0] d; logic [4:0] t;
    logic [31:0] br_d; logic br_e;
    exp_t r;
    send_one(16'h8004, 2'd0, 5'd7, v, d, t, e);
    checks++; if (v !== 1'b1 || d !== 32'hFFFF8004 || t !== 5'd7 || e !== 1'b0)
      begin errors++; $display("FAIL sign_8004 got v=%b %h tag %0d err %b want 1 ffff8004 7 0", v, d, t, e); end
    send_one(16'h8004, 2'd1, 5'd8, v, d, t, e);
    checks++; if (d !== 32'h00008004 || e !== 1'b0) begin errors++; $display("FAIL zero_8004 got %h err %b want 00008004 0", d, e); end
    send_one(16'h1234, 2'd2, 5'd9, v, d, t, e);
    checks++; if (d !== 32'h12340000 || e !== 1'b0) begin errors++; $display("FAIL upper_1234 got %h err %b want 12340000 0", d, e); end
`ifdef IMM_EXT_BRANCH_EN
    br_d = 32'hFFFFFFFC; br_e = 1'b0;
`else
    br_d = 32'hFFFFFFFF; br_e = 1'b1;
`endif
    send_one(16'hFFFF, 2'd3, 5'd10, v, d, t, e);
    checks++; if (d !== br_d || e !== br_e) begin errors++; $display("FAIL branch_ffff got %h err %b want %h %b", d, e, br_d, br_e); end
    for (int i = 0; i < 16; i++) begin
      logic [15:0] imm; logic [1:0] md; logic [4:0] tg;
      imm = 16'($urandom); md = 2'(i % 4); tg = 5'($urandom);
      r = ref_ext(imm, md, tg);
      send_one(imm, md, tg, v, d, t, e);
      checks++; if (v !== 1'b1 || d !== r.data || t !== r.tag || e !== r.err)
        begin errors++; $display("FAIL mode_rand imm %h mode %0d got %b %h %0d %b want 1 %h %0d %b", imm, md, v, d, t, e, r.data, r.tag, r.err); end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0]  got[$];
    logic [31:0] held;
    logic        acc;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'd0; in_imm = 16'h0101; in_tag = 5'd1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_first got %b want 1", in_ready); end
    tick();
    in_imm = 16'h0202; in_tag = 5'd2;
    tick();
    in_imm = 16'h0303; in_tag = 5'd3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
    held = out_data;
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1 || out_data !== held)
      begin errors++; $display("FAIL bp_hold got rdy %b vld %b tag %0d data %h want 0 1 1 %h", in_ready, out_valid, out_tag, out_data, held); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      acc = in_valid && in_ready;
      if (out_valid) got.push_back(out_tag);
      tick();
      if (acc) in_valid = 1'b0;
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_out_count got %0d want 3", got.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got[i] !== 5'(i + 1)) begin errors++; $display("FAIL bp_order idx %0d got %0d want %0d", i, got[i], i + 1); end
      end
    end
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL bp_count got %0d want 3", count); end
  endtask

  task automatic test_random();
    int   occ;
    exp_t h;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 5);
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      in_tag    = 5'($urandom);
      #1;
      occ = q.size();
      checks++; if (in_ready !== (occ < 2)) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, in_ready, occ < 2); end
      checks++; if (out_valid !== (occ > 0)) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", c, out_valid, occ > 0); end
      if (occ > 0) begin
        h = q[0];
        checks++; if (out_data !== h.data || out_tag !== h.tag || out_err !== h.err)
          begin errors++; $display("FAIL rnd_out cyc %0d got %h %0d %b want %h %0d %b", c, out_data, out_tag, out_err, h.data, h.tag, h.err); end
      end
      if (out_ready && occ > 0) begin
        void'(q.pop_front());
        exp_count = exp_count + 16'd1;
      end
      if (in_valid && occ < 2) q.push_back(ref_ext(in_imm, in_mode, in_tag));
      tick();
    end
    checks++; if (count !== exp_count) begin errors++; $display("FAIL rnd_count got %0d want %0d", count, exp_count); end
  endtask

  task automatic test_back_to_back();
    int drops = 0;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_mode = 2'd1; in_tag = 5'd0;
    for (int i = 0; i < 70001; i++) begin
      in_imm = 16'(i);
      if (in_ready !== 1'b1) drops++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (drops != 0) begin errors++; $display("FAIL b2b_ready_drops got %0d want 0", drops); end
    checks++; if (count !== 16'(70000 % 65536)) begin errors++; $display("FAIL b2b_count got %0d want %0d", count, 70000 % 65536); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'(70000 % 65536))
      begin errors++; $display("FAIL b2b_last got %b %h want 1 %h", out_valid, out_data, 32'(70000 % 65536)); end
  endtask

  task automatic test_reset_full();
    int stale = 0;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_imm = 16'h4444; in_tag = 5'd4;
    tick();
    in_tag = 5'd5;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rf_full got rdy %b vld %b want 0 1", in_ready, out_valid); end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 16'd0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL rf_reset got vld %b count %0d rdy %b want 0 0 0", out_valid, count, in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rf_ready_after got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0 || count !== 16'd0) begin errors++; $display("FAIL rf_stale got %0d valid cycles count %0d want 0 0", stale, count); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
